imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory: streams program words in
//  over a valid/ready handshake and issues sequential word writes into the
//  instruction store. Sits between the boot/test source and the memory's write
//  port. Holds the datapath off (busy) until the image is fully written.
// PARAMETERS
//  DEPTH   9   number of 32-bit words in the instruction store (max image size)
//  DATA_W  32  instruction word width
//  ADDR_W  32  byte-address width of the write port
// PORTS
//  clk        in   1       rising-edge clock
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       pulse: begin a new load (honoured in IDLE/DONE only)
//  in_valid   in   1       source presents a word
//  in_data    in   DATA_W  instruction word
//  in_last    in   1       qualifies final word of the image
//  in_ready   out  1       loader accepts a word this cycle
//  wr_en      out  1       memory write strobe (one cycle per word)
//  wr_addr    out  ADDR_W  byte address of write (word_index*4)
//  wr_data    out  DATA_W  word to write
//  busy       out  1       load in progress; datapath must stay stalled
//  done       out  1       image written; sticky until next start/reset
//  overflow   out  1       image exceeded DEPTH words; sticky with done
//  word_count out  ADDR_W  words written in current/last load
//  checksum   out  DATA_W  XOR of written words (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; in_ready, wr_en, busy, done, overflow=0;
//   wr_addr, wr_data, word_count, checksum=0. Reset mid-load aborts it; no
//   further writes; memory contents left as-is.
//  FSM IDLE -> LOAD on start; DONE -> LOAD on start; LOAD -> DONE on last beat.
//  Entering LOAD: word_count=0, checksum=0, done=0, overflow=0, busy=1.
//  LOAD: in_ready=1 (combinational from state). Beat = in_valid && in_ready.
//  Beat at index i: next cycle wr_en=1, wr_addr=i*4, wr_data=in_data,
//   word_count=i+1. Latency from accepted beat to write strobe: 1 cycle.
//   Back-to-back beats give back-to-back writes, no bubbles.
//  Last beat = beat with in_last=1 OR beat with index DEPTH-1. Its write is
//   still issued; state -> DONE the same edge; in_ready=0 from then on.
//  Index DEPTH-1 without in_last: overflow=1 (image truncated to DEPTH words).
//  DONE: busy=0, done=1, wr_en=0; outputs hold until start or reset.
//  start while in LOAD: ignored. start and a beat in IDLE/DONE same cycle:
//   beat not accepted (in_ready=0); load begins next cycle.
//  in_valid with in_ready=0: no effect; source must hold data (standard
//   valid/ready: valid not dropped before acceptance).
//  wr_addr never exceeds (DEPTH-1)*4; word_count never exceeds DEPTH.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: checksum updates with each write,
//   checksum_next = checksum ^ wr_data, registered with wr_en; cleared on
//   entering LOAD. Not defined: checksum tied to 0, no XOR logic built.
// TESTING
//  1 reset, start, 3 beats (0x20080005,0x20090003,0x01095020, last on 3rd) ->
//    writes at 0x0,0x4,0x8 one cycle after each beat; done=1, word_count=3.
//  2 valid toggled 1/0 with gaps of 2 cycles -> writes only on accepted beats,
//    addresses contiguous, no duplicate writes.
//  3 10 words, no in_last -> 9 writes (0x0..0x20), overflow=1, done=1,
//    in_ready=0 afterwards, 10th word never written.
//  4 rst_n low after 2nd beat -> all outputs 0 asynchronously, no wr_en; new
//    start reloads from address 0x0.
//  5 start during LOAD, then second start in DONE -> first ignored; second
//    clears done/word_count and restarts at 0x0.
//  6 with IMEM_LOADER_CHECKSUM_EN, words 0xFFFF0000,0x0F0F0F0F -> checksum
//    0xF0F00F0F; without macro -> checksum stays 0.

Source files
------------

// File: rtl/imem_loader.sv
// Streams program words in over valid/ready and writes them sequentially into the instruction store.
// Optional running XOR checksum of written words: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int DEPTH  = 9,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W-1:0] word_count,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic [ADDR_W-1:0] word_count_q, word_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_q, checksum_d;
`endif

  logic beat;
  logic at_end;

  assign in_ready = (state_q == S_LOAD);
  assign beat     = in_valid && in_ready;
  // word_count_q is also the index of the beat being accepted this cycle
  assign at_end   = (word_count_q == ADDR_W'(DEPTH - 1));

  always_comb begin
    state_d      = state_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    busy_d       = busy_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    word_count_d = word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    checksum_d   = checksum_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d      = S_LOAD;
          word_count_d = '0;
          done_d       = 1'b0;
          overflow_d   = 1'b0;
          busy_d       = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum_d   = '0;
`endif
        end
      end
      S_LOAD: begin
        if (beat) begin
          wr_en_d      = 1'b1;
          wr_addr_d    = {word_count_q[ADDR_W-3:0], 2'b00};
          wr_data_d    = in_data;
          word_count_d = word_count_q + ADDR_W'(1);
`ifdef IMEM_LOADER_CHECKSUM_EN
          checksum_d   = checksum_q ^ in_data;
`endif
          if (in_last || at_end) begin
            state_d    = S_DONE;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            overflow_d = at_end && !in_last;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      word_count_q <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      word_count_q <= word_count_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      checksum_q   <= checksum_d;
`endif
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign overflow   = overflow_q;
  assign word_count = word_count_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`else
  assign checksum   = '0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected writes queued at each accepted beat, popped on wr_en.
module tb_imem_loader;
  localparam int DEPTH = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        in_ready, wr_en, busy, done, overflow;
  logic [31:0] wr_addr, wr_data, word_count, checksum;

  imem_loader #(.DEPTH(DEPTH), .DATA_W(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .overflow(overflow),
    .word_count(word_count), .checksum(checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  failures = 0;
  int  cyc = 0;

  // reference model: 0 idle, 1 load, 2 done
  int          m_state = 0;
  int          m_idx = 0;
  bit          m_ovf = 1'b0;
  logic [31:0] m_csum = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] exp_csum();
`ifdef IMEM_LOADER_CHECKSUM_EN
    return m_csum;
`else
    return 32'h0;
`endif
  endfunction

  always @(negedge clk) begin
    if (wr_en) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 32'd1, 32'd0);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr", wr_addr, e.addr);
        chk("wr_data", wr_data, e.data);
        chk("wr_latency", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_ovf = 1'b0; m_csum = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_state != 1) begin
      m_state = 1; m_idx = 0; m_ovf = 1'b0; m_csum = '0;
    end
  endtask

  task automatic send(input logic [31:0] d, input bit last, input int gap);
    in_valid = 1'b1; in_data = d; in_last = last;
    #1;
    chk("in_ready", {31'd0, in_ready}, {31'd0, m_state == 1});
    if (m_state == 1) begin
      exp_q.push_back('{addr: 32'(m_idx * 4), data: d, cyc: cyc + 1});
      m_idx++;
      m_csum ^= d;
      if (last || m_idx == DEPTH) begin
        m_ovf = !last;
        m_state = 2;
      end
    end
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic check_status(input string tag);
    #1;
    chk({tag, "_busy"},     {31'd0, busy},     {31'd0, m_state == 1});
    chk({tag, "_done"},     {31'd0, done},     {31'd0, m_state == 2});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, m_ovf});
    chk({tag, "_count"},    word_count,        32'(m_idx));
    chk({tag, "_checksum"}, checksum,          exp_csum());
    chk({tag, "_ready"},    {31'd0, in_ready}, {31'd0, m_state == 1});
  endtask

  task automatic drain(input string tag);
    repeat (2) @(negedge clk);
    chk({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_status("reset");
    chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
    chk("reset_wr_addr", wr_addr, 32'd0);
    chk("reset_wr_data", wr_data, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // basic three-word image
    pulse_start();
    check_status("t1_start");
    send(32'h2008_0005, 1'b0, 0);
    send(32'h2009_0003, 1'b0, 0);
    send(32'h0109_5020, 1'b1, 0);
    check_status("t1_done");
    drain("t1");

    // valid with gaps
    pulse_start();
    for (int i = 0; i < 4; i++) send(32'h1111_0000 + 32'(i * 7), i == 3, 2);
    drain("t2");
    check_status("t2_done");

    // ten words, no last: truncated to DEPTH
    pulse_start();
    for (int i = 0; i < 10; i++) send(32'hA000_0000 + 32'(i), 1'b0, 0);
    drain("t3");
    check_status("t3_overflow");

    // reset after second beat
    pulse_start();
    send(32'hDEAD_0001, 1'b0, 0);
    send(32'hDEAD_0002, 1'b0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'd0, wr_en}, 32'd0);
    chk("rst_wr_addr", wr_addr, 32'd0);
    chk("rst_wr_data", wr_data, 32'd0);
    model_reset();
    check_status("t4_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drain("t4_abort");
    pulse_start();
    send(32'h0000_BEEF, 1'b1, 0);
    drain("t4");
    check_status("t4_reload");

    // start during LOAD ignored, start in DONE restarts
    pulse_start();
    send(32'h5555_0001, 1'b0, 0);
    pulse_start();
    check_status("t5_ignored");
    send(32'h5555_0002, 1'b1, 0);
    check_status("t5_done");
    pulse_start();
    check_status("t5_restart");
    send(32'h5555_0003, 1'b1, 0);
    drain("t5");

    // start and valid together in DONE: beat waits for LOAD
    start = 1'b1; in_valid = 1'b1; in_data = 32'hFFFF_0000; in_last = 1'b0;
    #1;
    chk("t6_ready_on_start", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    m_state = 1; m_idx = 0; m_ovf = 1'b0; m_csum = '0;
    send(32'hFFFF_0000, 1'b0, 0);
    send(32'h0F0F_0F0F, 1'b1, 0);
    drain("t6");
    check_status("t6_done");
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("t6_checksum_const", checksum, 32'hF0F0_0F0F);
`else
    chk("t6_checksum_const", checksum, 32'h0000_0000);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
